race_referee: RTL and testbench

// Round controller and judge for Red Light, Green Light; consumes car positions from the car manager and drives its

---
 rtl/race_referee_pkg.sv | 60 ++++++
 rtl/race_referee_if.sv | 32 +++
 rtl/race_referee_phase_timer.sv | 39 +++
 rtl/race_referee.sv | 238 +++++++++++++++++++++++
 tb/tb_race_referee.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/race_referee_pkg.sv
// Shared types and constants for the Red Light, Green Light round referee.
package race_referee_pkg;

  // Round sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_GREEN     = 3'd2,
    ST_RED       = 3'd3,
    ST_RESULT    = 3'd4
  } state_e;

  // Winner codes as shown on the display.
  typedef enum logic [2:0] {
    WIN_NONE   = 3'd0,
    WIN_PLAYER = 3'd1,
    WIN_AI1    = 3'd2,
    WIN_AI2    = 3'd3,
    WIN_AI3    = 3'd4
  } winner_e;

  localparam int unsigned TIMER_W       = 28;
  localparam logic [9:0]  FINISH_X      = 10'd580;
  localparam logic [9:0]  START_X       = 10'd50;
  localparam logic [3:0]  TALLY_MAX     = 4'd9;
  localparam logic [1:0]  SETTLE_CYCLES = 2'd2;

  // Win tally increment that sticks at the display maximum.
  function automatic logic [3:0] tally_inc(input logic [3:0] tally);
    logic [3:0] nxt;
    if (tally >= TALLY_MAX) begin
      nxt = TALLY_MAX;
    end else begin
      nxt = tally + 4'd1;
    end
    return nxt;
  endfunction

  // First car at or past the finish line, player first, then ai1..ai3.
  function automatic winner_e pick_winner(input logic [9:0] p_x,
                                          input logic [9:0] a1_x,
                                          input logic [9:0] a2_x,
                                          input logic [9:0] a3_x,
                                          input logic [9:0] line_x);
    winner_e w;
    if (p_x >= line_x) begin
      w = WIN_PLAYER;
    end else if (a1_x >= line_x) begin
      w = WIN_AI1;
    end else if (a2_x >= line_x) begin
      w = WIN_AI2;
    end else if (a3_x >= line_x) begin
      w = WIN_AI3;
    end else begin
      w = WIN_NONE;
    end
    return w;
  endfunction

endpackage

// File: rtl/race_referee_if.sv
// Connection bundle between the referee, the car manager and the display.
interface race_referee_if;
  logic        start;
  logic [15:0] rand_val;
  logic [9:0]  player_x;
  logic [9:0]  ai1_x;
  logic [9:0]  ai2_x;
  logic [9:0]  ai3_x;
  logic        game_active;
  logic        light_green;
  logic        light_red;
  logic [1:0]  countdown;
  logic        round_over;
  logic [2:0]  winner;
  logic        player_out;
  logic [3:0]  player_wins;
  logic [3:0]  ai_wins;

  // Game side: supplies positions/start/random, observes the referee.
  modport master (
    output start, rand_val, player_x, ai1_x, ai2_x, ai3_x,
    input  game_active, light_green, light_red, countdown, round_over,
           winner, player_out, player_wins, ai_wins
  );

  // Referee side.
  modport slave (
    input  start, rand_val, player_x, ai1_x, ai2_x, ai3_x,
    output game_active, light_green, light_red, countdown, round_over,
           winner, player_out, player_wins, ai_wins
  );
endinterface

// File: rtl/race_referee_phase_timer.sv
// 28-bit restartable up-counter with a terminal-count flag.
module race_referee_phase_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [27:0] last_i,
  output logic [27:0] count_o,
  output logic        done_o
);

  logic [27:0] count_q;
  logic [27:0] count_d;

  // Next count: load restarts at zero and wins over counting.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = 28'd0;
    end else if (en_i) begin
      count_d = count_q + 28'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 28'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = (count_q == last_i);

endmodule

// File: rtl/race_referee.sv
// Round controller and judge: countdown, green/red alternation, finish and
// red-light violation detection, winner and saturating win tallies.
module race_referee #(
  parameter int unsigned COUNT_STEP  = 50_000_000,
  parameter int unsigned GREEN_MIN   = 75_000_000,
  parameter int unsigned RED_MIN     = 50_000_000,
  parameter int unsigned PHASE_STEP  = 6_250_000,
  parameter int unsigned GRACE       = 12_500_000,
  parameter int unsigned RESULT_HOLD = 150_000_000,
  parameter logic [9:0]  FINISH_LINE = race_referee_pkg::FINISH_X
) (
  input logic           clk,
  input logic           reset_n,
  race_referee_if.slave bus
);
  import race_referee_pkg::*;

  localparam logic [27:0] COUNT_LAST = 28'(COUNT_STEP - 32'd1);
  localparam logic [27:0] HOLD_LAST  = 28'(RESULT_HOLD - 32'd1);
  localparam logic [27:0] GRACE_T    = 28'(GRACE);

  state_e      state_q, state_d;
  logic [1:0]  digit_q, digit_d;
  logic [27:0] len_q, len_d;
  logic [1:0]  settle_q, settle_d;
  logic [9:0]  prev_x_q, prev_x_d;
  logic [3:0]  pwins_q, pwins_d;
  logic [3:0]  awins_q, awins_d;
  winner_e     winner_q, winner_d;
  logic        player_out_q, player_out_d;
  logic        game_active_q, game_active_d;
  logic        light_green_q, light_green_d;
  logic        light_red_q, light_red_d;
  logic [1:0]  countdown_q, countdown_d;
  logic        round_over_q, round_over_d;

  logic        ph_load_s, ph_en_s, ph_done_s;
  logic [27:0] ph_last_s, ph_count_s;
  logic        hold_load_s, hold_en_s, hold_done_s;
  logic [27:0] hold_count_unused;
  logic [11:0] rand_low_unused;

  logic [27:0] green_len_s, red_len_s;
  logic        checks_on_s, viol_s, finish_s;
  winner_e     fin_win_s;

  assign rand_low_unused = bus.rand_val[11:0];

  // Next-state, timer control, judging and registered-output decode.
  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    len_d        = len_q;
    pwins_d      = pwins_q;
    awins_d      = awins_q;
    winner_d     = winner_q;
    player_out_d = player_out_q;
    ph_load_s    = 1'b0;
    ph_en_s      = 1'b0;
    hold_load_s  = 1'b0;
    hold_en_s    = 1'b0;

    green_len_s = 28'(GREEN_MIN) + 28'(bus.rand_val[15:12]) * 28'(PHASE_STEP);
    red_len_s   = 28'(RED_MIN)   + 28'(bus.rand_val[15:12]) * 28'(PHASE_STEP);

    if (state_q == ST_COUNTDOWN) begin
      ph_last_s = COUNT_LAST;
    end else begin
      ph_last_s = len_q - 28'd1;
    end

    // Settle window counts down once armed at the first green.
    if (settle_q != 2'd0) begin
      settle_d = settle_q - 2'd1;
    end else begin
      settle_d = settle_q;
    end

    if ((state_q == ST_GREEN) || (state_q == ST_RED)) begin
      prev_x_d = bus.player_x;
    end else begin
      prev_x_d = prev_x_q;
    end

    checks_on_s = (settle_q == 2'd0);
    fin_win_s   = pick_winner(bus.player_x, bus.ai1_x, bus.ai2_x, bus.ai3_x, FINISH_LINE);
    viol_s      = (state_q == ST_RED) && checks_on_s && (ph_count_s >= GRACE_T) &&
                  (bus.player_x > prev_x_q);
    finish_s    = checks_on_s && (fin_win_s != WIN_NONE);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_COUNTDOWN;
          digit_d   = 2'd3;
          ph_load_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COUNTDOWN: begin
        ph_en_s = 1'b1;
        if (ph_done_s) begin
          ph_load_s = 1'b1;
          if (digit_q == 2'd1) begin
            state_d  = ST_GREEN;
            digit_d  = 2'd0;
            len_d    = green_len_s;
            settle_d = SETTLE_CYCLES;
          end else begin
            digit_d = digit_q - 2'd1;
          end
        end else begin
          state_d = ST_COUNTDOWN;
        end
      end
      ST_GREEN, ST_RED: begin
        ph_en_s = 1'b1;
        if (viol_s) begin
          state_d      = ST_RESULT;
          winner_d     = WIN_NONE;
          player_out_d = 1'b1;
          awins_d      = tally_inc(awins_q);
          hold_load_s  = 1'b1;
        end else if (finish_s) begin
          state_d     = ST_RESULT;
          winner_d    = fin_win_s;
          hold_load_s = 1'b1;
          if (fin_win_s == WIN_PLAYER) begin
            pwins_d = tally_inc(pwins_q);
          end else begin
            awins_d = tally_inc(awins_q);
          end
        end else if (ph_done_s) begin
          ph_load_s = 1'b1;
          if (state_q == ST_GREEN) begin
            state_d = ST_RED;
            len_d   = red_len_s;
          end else begin
            state_d = ST_GREEN;
            len_d   = green_len_s;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_RESULT: begin
        hold_en_s = 1'b1;
        if (hold_done_s) begin
          state_d      = ST_IDLE;
          winner_d     = WIN_NONE;
          player_out_d = 1'b0;
        end else begin
          state_d = ST_RESULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    game_active_d = (state_d == ST_GREEN) || (state_d == ST_RED);
    light_green_d = (state_d == ST_GREEN);
    light_red_d   = (state_d == ST_RED);
    round_over_d  = (state_d == ST_RESULT);
    if (state_d == ST_COUNTDOWN) begin
      countdown_d = digit_d;
    end else begin
      countdown_d = 2'd0;
    end
  end

  // Round state, judging registers, tallies and display outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      digit_q       <= 2'd0;
      len_q         <= 28'd0;
      settle_q      <= 2'd0;
      prev_x_q      <= 10'd0;
      pwins_q       <= 4'd0;
      awins_q       <= 4'd0;
      winner_q      <= WIN_NONE;
      player_out_q  <= 1'b0;
      game_active_q <= 1'b0;
      light_green_q <= 1'b0;
      light_red_q   <= 1'b0;
      countdown_q   <= 2'd0;
      round_over_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      digit_q       <= digit_d;
      len_q         <= len_d;
      settle_q      <= settle_d;
      prev_x_q      <= prev_x_d;
      pwins_q       <= pwins_d;
      awins_q       <= awins_d;
      winner_q      <= winner_d;
      player_out_q  <= player_out_d;
      game_active_q <= game_active_d;
      light_green_q <= light_green_d;
      light_red_q   <= light_red_d;
      countdown_q   <= countdown_d;
      round_over_q  <= round_over_d;
    end
  end

  race_referee_phase_timer u_phase_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (ph_load_s),
    .en_i    (ph_en_s),
    .last_i  (ph_last_s),
    .count_o (ph_count_s),
    .done_o  (ph_done_s)
  );

  race_referee_phase_timer u_hold_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (hold_load_s),
    .en_i    (hold_en_s),
    .last_i  (HOLD_LAST),
    .count_o (hold_count_unused),
    .done_o  (hold_done_s)
  );

  assign bus.game_active = game_active_q;
  assign bus.light_green = light_green_q;
  assign bus.light_red   = light_red_q;
  assign bus.countdown   = countdown_q;
  assign bus.round_over  = round_over_q;
  assign bus.winner      = winner_q;
  assign bus.player_out  = player_out_q;
  assign bus.player_wins = pwins_q;
  assign bus.ai_wins     = awins_q;

endmodule

// File: tb/tb_race_referee.sv
// Directed plus randomized bench for race_referee with short sim timings.
module tb_race_referee;
  localparam int COUNT_STEP  = 4;
  localparam int GREEN_MIN   = 20;
  localparam int RED_MIN     = 20;
  localparam int PHASE_STEP  = 2;
  localparam int GRACE       = 3;
  localparam int RESULT_HOLD = 10;
  localparam int FINISH_X    = 580;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   exp_pw = 0;
  int   exp_aw = 0;
  int   last_p = 0;

  race_referee_if bus ();

  race_referee #(
    .COUNT_STEP  (COUNT_STEP),
    .GREEN_MIN   (GREEN_MIN),
    .RED_MIN     (RED_MIN),
    .PHASE_STEP  (PHASE_STEP),
    .GRACE       (GRACE),
    .RESULT_HOLD (RESULT_HOLD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rules
  function automatic int plen(input bit green, input int nib);
    return (green ? GREEN_MIN : RED_MIN) + nib * PHASE_STEP;
  endfunction

  function automatic int judge(input int p, input int a1, input int a2, input int a3);
    int xs[4];
    xs = '{p, a1, a2, a3};
    for (int i = 0; i < 4; i++) begin
      if (xs[i] >= FINISH_X) return i + 1;
    end
    return 0;
  endfunction

  function automatic int sat9(input int v);
    return (v > 9) ? 9 : v;
  endfunction

  task automatic set_pos(input int p, input int a1, input int a2, input int a3);
    bus.player_x = 10'(p);
    bus.ai1_x    = 10'(a1);
    bus.ai2_x    = 10'(a2);
    bus.ai3_x    = 10'(a3);
    last_p       = p;
  endtask

  // Random legal movement: free in green, never forward in red.
  task automatic move(input bit green);
    int p;
    if (green) p = int'($urandom_range(50, 579));
    else       p = int'($urandom_range(0, last_p));
    set_pos(p, int'($urandom_range(0, 579)), int'($urandom_range(0, 579)),
            int'($urandom_range(0, 579)));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_active"}, 32'(bus.game_active), 0);
    check({tag, "_green"},  32'(bus.light_green), 0);
    check({tag, "_red"},    32'(bus.light_red), 0);
    check({tag, "_cd"},     32'(bus.countdown), 0);
    check({tag, "_over"},   32'(bus.round_over), 0);
    check({tag, "_winner"}, 32'(bus.winner), 0);
    check({tag, "_out"},    32'(bus.player_out), 0);
    check({tag, "_pwins"},  32'(bus.player_wins), 32'(exp_pw));
    check({tag, "_awins"},  32'(bus.ai_wins), 32'(exp_aw));
  endtask

  task automatic start_round(input int nib);
    bus.rand_val = 16'($urandom);
    bus.rand_val[15:12] = 4'(nib);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int d = 3; d >= 1; d--) begin
      for (int k = 0; k < COUNT_STEP; k++) begin
        check("countdown", 32'(bus.countdown), 32'(d));
        tick();
      end
    end
    check("green_entry_light", 32'(bus.light_green), 1);
    check("green_entry_active", 32'(bus.game_active), 1);
  endtask

  task automatic run_phase(input bit green, input int exp_len, input int next_nib, input bit mv);
    int n = 0;
    bus.rand_val[15:12] = 4'(next_nib);
    while (((green ? bus.light_green : bus.light_red) === 1'b1) && (n < 1000)) begin
      n++;
      if (mv) move(green);
      tick();
    end
    check(green ? "green_len" : "red_len", 32'(n), 32'(exp_len));
    check("next_light", 32'(green ? bus.light_red : bus.light_green), 1);
  endtask

  task automatic check_result(input int w, input int out);
    check("res_over",   32'(bus.round_over), 1);
    check("res_active", 32'(bus.game_active), 0);
    check("res_winner", 32'(bus.winner), 32'(w));
    check("res_out",    32'(bus.player_out), 32'(out));
    check("res_pwins",  32'(bus.player_wins), 32'(exp_pw));
    check("res_awins",  32'(bus.ai_wins), 32'(exp_aw));
  endtask

  task automatic wait_result_end();
    int n = 0;
    while ((bus.round_over === 1'b1) && (n < 100)) begin
      n++;
      tick();
    end
    check("result_hold", 32'(n), 32'(RESULT_HOLD));
    check("idle_winner", 32'(bus.winner), 0);
    check("idle_out", 32'(bus.player_out), 0);
  endtask

  task automatic player_win_round(input int nib);
    set_pos(50, 50, 50, 50);
    start_round(nib);
    tick();
    tick();
    set_pos(int'($urandom_range(580, 1023)), 50, 50, 50);
    tick();
    exp_pw = sat9(exp_pw + 1);
    check_result(1, 0);
    wait_result_end();
  endtask

  int  nph, k, nn, len, p, a1, a2, a3, mask, w;
  bit  g, v;

  initial begin
    bus.start = 1'b0;
    bus.rand_val = 16'd0;
    set_pos(0, 0, 0, 0);
    reset_n = 1'b0;
    repeat (3) tick();
    check_quiet("reset");
    reset_n = 1'b1;
    tick();
    check_quiet("idle");

    // Countdown, then fixed-length green/red phases without movement.
    set_pos(50, 50, 50, 50);
    start_round(5);
    run_phase(1'b1, 30, 0, 1'b0);
    run_phase(1'b0, 20, 0, 1'b0);
    run_phase(1'b1, 20, 0, 1'b0);

    // Movement inside the grace window is ignored; later movement eliminates.
    tick();
    set_pos(55, 50, 50, 50);
    tick();
    tick();
    tick();
    check("grace_move_ignored", 32'(bus.round_over), 0);
    tick();
    set_pos(60, 50, 50, 50);
    tick();
    exp_aw = sat9(exp_aw + 1);
    check_result(0, 1);
    wait_result_end();

    // Same-cycle finish by ai2 and player: player has priority.
    set_pos(50, 50, 50, 50);
    start_round(0);
    tick();
    tick();
    set_pos(580, 50, 580, 50);
    tick();
    exp_pw = sat9(exp_pw + 1);
    check_result(judge(580, 50, 580, 50), 0);
    wait_result_end();

    // Stale positions during the settle window do not score.
    set_pos(600, 50, 50, 50);
    start_round(3);
    check("settle0_over", 32'(bus.round_over), 0);
    tick();
    check("settle1_over", 32'(bus.round_over), 0);
    tick();
    check("settle2_over", 32'(bus.round_over), 0);
    check("settle2_green", 32'(bus.light_green), 1);
    set_pos(50, 50, 50, 50);
    tick();
    check("settle_play_on", 32'(bus.round_over), 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_ignored_cd", 32'(bus.countdown), 0);
    check("start_ignored_green", 32'(bus.light_green), 1);
    set_pos(590, 50, 50, 50);
    tick();
    exp_pw = sat9(exp_pw + 1);
    check_result(1, 0);
    wait_result_end();

    // Player tally saturates.
    for (int r = 0; r < 9; r++) player_win_round(int'($urandom_range(0, 15)));
    check("pwins_saturated", 32'(bus.player_wins), 9);

    // Randomized rounds against the reference rules.
    for (int r = 0; r < 8; r++) begin
      set_pos(50, 50, 50, 50);
      nn = int'($urandom_range(0, 15));
      start_round(nn);
      g   = 1'b1;
      len = plen(1'b1, nn);
      nph = int'($urandom_range(0, 2));
      for (int ph = 0; ph < nph; ph++) begin
        nn = int'($urandom_range(0, 15));
        run_phase(g, len, nn, 1'b1);
        g   = ~g;
        len = plen(g, nn);
      end
      k = int'($urandom_range(GRACE, 15));
      for (int j = 0; j < k; j++) begin
        move(g);
        tick();
      end
      if (!g && ($urandom_range(0, 1) == 1)) begin
        p  = last_p + int'($urandom_range(1, 10));
        a1 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(580, 1023)) : int'($urandom_range(0, 579));
        a2 = int'($urandom_range(0, 579));
        a3 = int'($urandom_range(0, 579));
      end else begin
        mask = int'($urandom_range(1, 15));
        p  = mask[0] ? int'($urandom_range(580, 1023))
                     : (g ? int'($urandom_range(50, 579)) : int'($urandom_range(0, last_p)));
        a1 = mask[1] ? int'($urandom_range(580, 1023)) : int'($urandom_range(0, 579));
        a2 = mask[2] ? int'($urandom_range(580, 1023)) : int'($urandom_range(0, 579));
        a3 = mask[3] ? int'($urandom_range(580, 1023)) : int'($urandom_range(0, 579));
      end
      v = !g && (k >= GRACE) && (p > last_p);
      w = v ? 0 : judge(p, a1, a2, a3);
      if (v || (w != 1)) exp_aw = sat9(exp_aw + 1);
      else               exp_pw = sat9(exp_pw + 1);
      set_pos(p, a1, a2, a3);
      tick();
      check_result(w, v ? 1 : 0);
      wait_result_end();
    end

    // Asynchronous reset in the middle of a red phase.
    set_pos(50, 50, 50, 50);
    start_round(0);
    run_phase(1'b1, 20, 0, 1'b1);
    tick();
    tick();
    check("pre_reset_red", 32'(bus.light_red), 1);
    reset_n = 1'b0;
    #2;
    exp_pw = 0;
    exp_aw = 0;
    check_quiet("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_quiet("post_reset");
    player_win_round(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
